ps2_keyboard_port: RTL and testbench

PS2_KEYBOARD_PORT -- requirements
Module: ps2_keyboard_port

---
 rtl/ps2_keyboard_port.sv | 141 ++++++++++++++
 tb/tb_ps2_keyboard_port.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_port.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 lines, deframes
// 11-bit frames (start, 8 data LSB first, odd parity, stop), folds the
// E0/F0 prefix bytes into flags, and holds one key code for the CPU.
module ps2_keyboard_port #(
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        keyboard_clear_on_read,
    output logic [15:0] keyboard_data,
    output logic        overrun,
    output logic        frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic [2:0]    ps2_clk_sync;   // [0],[1] synchronizer, [2] edge history
    logic [1:0]    ps2_data_sync;
    logic          fall;
    logic          sdata;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          timeout_hit;
    logic          ext_pending, brk_pending;
    logic          stop_edge, byte_ok, byte_bad, code_valid;
    logic [15:0]   code;

    assign sdata = ps2_data_sync[1];
    assign fall  = ps2_clk_sync[2] & ~ps2_clk_sync[1];
    assign timeout_hit = (state != IDLE) && !fall && (tcnt == TO_LAST);

    // Bring the asynchronous PS/2 lines into the clk domain (idle high)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2_clk_sync  <= 3'b111;
            ps2_data_sync <= 2'b11;
        end else begin
            ps2_clk_sync  <= {ps2_clk_sync[1:0], ps2_clk};
            ps2_data_sync <= {ps2_data_sync[0], ps2_data};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // FSM next-state: one transition per ps2_clk falling edge, or abandon on timeout
    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (fall && !sdata) state_n = DATA;
            DATA:   if (timeout_hit) state_n = IDLE;
                    else if (fall && bit_cnt == 3'd7) state_n = PARITY;
            PARITY: if (timeout_hit) state_n = IDLE;
                    else if (fall) state_n = STOP;
            STOP:   if (timeout_hit || fall) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM outputs: classify the frame on the stop-bit edge
    always_comb begin
        stop_edge  = (state == STOP) && fall;
        byte_ok    = stop_edge && sdata && (^{shift_reg, par_bit});
        byte_bad   = stop_edge && !(sdata && (^{shift_reg, par_bit}));
        code_valid = byte_ok && (shift_reg != 8'hE0) && (shift_reg != 8'hF0);
        code       = {1'b1, brk_pending, ext_pending, 5'b0, shift_reg};
    end

    // Bit counter, shift register, parity capture and inter-edge timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tcnt      <= '0;
        end else begin
            if (state == IDLE || fall || timeout_hit) tcnt <= '0;
            else                                      tcnt <= tcnt + TW'(1);
            if (fall) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift_reg <= {sdata, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                    PARITY:  par_bit <= sdata;
                    default: ;
                endcase
            end
        end
    end

    // Prefix flags: E0 marks extended, F0 marks break; consumed by the next code
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
        end else if (byte_bad) begin
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
        end else if (byte_ok) begin
            if (shift_reg == 8'hE0)      ext_pending <= 1'b1;
            else if (shift_reg == 8'hF0) brk_pending <= 1'b1;
            else begin
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
            end
        end
    end

    // Held code register; a clear in the same cycle lets a new code in
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keyboard_data <= 16'h0000;
            overrun       <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            frame_error <= byte_bad;
            if (code_valid) begin
                if (keyboard_clear_on_read || !keyboard_data[15]) keyboard_data <= code;
                else                                              overrun <= 1'b1;
                if (keyboard_clear_on_read) overrun <= 1'b0;
            end else if (keyboard_clear_on_read) begin
                keyboard_data <= 16'h0000;
                overrun       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_port.sv
// Directed bench for ps2_keyboard_port: table of frames with expected
// codes, plus hand sequences for coincident clear, timeout and mid-frame reset.
module tb_ps2_keyboard_port;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] kd;
    logic        overrun;
    logic        frame_error;

    ps2_keyboard_port #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keyboard_clear_on_read(clr), .keyboard_data(kd),
        .overrun(overrun), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int fe_cnt = 0;

    always @(posedge clk) if (frame_error) fe_cnt <= fe_cnt + 1;

    logic [15:0] kd_before, kd_after;
    logic        fe_p3, fe_p4;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Full frame; the stop edge is timed so latency and the error pulse are observable
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit clr_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        @(negedge clk) ps2_data = ~bad_stop;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 kd_before = kd;
        if (clr_stop) @(negedge clk) clr = 1'b1;
        @(posedge clk);
        #1 kd_after = kd; fe_p3 = frame_error; clr = 1'b0;
        @(posedge clk);
        #1 fe_p4 = frame_error;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (3) @(negedge clk);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic partial(input logic [7:0] b, input int n);
        ps2_bit(1'b0);
        for (int i = 0; i < n; i++) ps2_bit(b[i]);
    endtask

    task automatic pulse_clear(input int n);
        @(negedge clk) clr = 1'b1;
        repeat (n) @(negedge clk);
        clr = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  b;
        bit          bad_par;
        bit          bad_stop;
        bit          clr;
        logic [15:0] kd;
        bit          ovr;
        bit          fe;
    } vec_t;

    vec_t tbl[16];
    logic [15:0] prev;
    int fe_mark;

    initial begin
        //          byte   bp  bs  clr  kd        ovr fe
        tbl[0]  = '{8'h1C, 0, 0, 0, 16'h801C, 0, 0};
        tbl[1]  = '{8'hE0, 0, 0, 1, 16'h0000, 0, 0};
        tbl[2]  = '{8'hF0, 0, 0, 0, 16'h0000, 0, 0};
        tbl[3]  = '{8'h74, 0, 0, 0, 16'hE074, 0, 0};
        tbl[4]  = '{8'hE0, 0, 0, 1, 16'h0000, 0, 0};
        tbl[5]  = '{8'h1C, 1, 0, 0, 16'h0000, 0, 1};
        tbl[6]  = '{8'hF0, 0, 0, 0, 16'h0000, 0, 0};
        tbl[7]  = '{8'h1C, 0, 0, 0, 16'hC01C, 0, 0};
        tbl[8]  = '{8'h1C, 0, 0, 1, 16'h801C, 0, 0};
        tbl[9]  = '{8'h32, 0, 0, 0, 16'h801C, 1, 0};
        tbl[10] = '{8'hE0, 0, 0, 0, 16'h801C, 1, 0};
        tbl[11] = '{8'h15, 0, 0, 0, 16'h801C, 1, 0};
        tbl[12] = '{8'h15, 0, 0, 1, 16'h8015, 0, 0};
        tbl[13] = '{8'hF0, 0, 0, 1, 16'h0000, 0, 0};
        tbl[14] = '{8'h1C, 0, 1, 0, 16'h0000, 0, 1};
        tbl[15] = '{8'h29, 0, 0, 0, 16'h8029, 0, 0};

        repeat (3) @(negedge clk);
        chk("reset kd", kd, 16'h0000);
        chk("reset overrun", {15'b0, overrun}, 16'h0);
        chk("reset frame_error", {15'b0, frame_error}, 16'h0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        prev = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].clr) begin
                pulse_clear(1);
                chk($sformatf("v%0d clear kd", i), kd, 16'h0000);
                chk($sformatf("v%0d clear overrun", i), {15'b0, overrun}, 16'h0);
                prev = 16'h0000;
            end
            send_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop, 1'b0);
            chk($sformatf("v%0d kd before latency", i), kd_before, prev);
            chk($sformatf("v%0d kd", i), kd_after, tbl[i].kd);
            chk($sformatf("v%0d overrun", i), {15'b0, overrun}, {15'b0, tbl[i].ovr});
            chk($sformatf("v%0d frame_error pulse", i), {15'b0, fe_p3}, {15'b0, tbl[i].fe});
            chk($sformatf("v%0d frame_error width", i), {15'b0, fe_p4}, 16'h0);
            prev = tbl[i].kd;
        end

        // Clear held several cycles, then clear coincident with a code on a full register
        send_frame(8'h32, 0, 0, 0);
        chk("A overrun set", {15'b0, overrun}, 16'h1);
        pulse_clear(3);
        chk("A held clear kd", kd, 16'h0000);
        chk("A held clear overrun", {15'b0, overrun}, 16'h0);
        send_frame(8'h1C, 0, 0, 0);
        send_frame(8'h32, 0, 0, 0);
        chk("A full kd", kd, 16'h801C);
        chk("A full overrun", {15'b0, overrun}, 16'h1);
        send_frame(8'h29, 0, 0, 1);
        chk("A coincident kd", kd_after, 16'h8029);
        chk("A coincident overrun", {15'b0, overrun}, 16'h0);

        // Partial frame abandoned by timeout; the F0 prefix must survive it
        pulse_clear(1);
        send_frame(8'hF0, 0, 0, 0);
        fe_mark = fe_cnt;
        partial(8'h1C, 4);
        repeat (TO + 20) @(negedge clk);
        chk("B timeout kd", kd, 16'h0000);
        chk("B timeout no frame_error", 16'(fe_cnt - fe_mark), 16'h0);
        send_frame(8'h29, 0, 0, 0);
        chk("B after timeout kd", kd_after, 16'hC029);
        chk("B after timeout frame_error", {15'b0, fe_p3}, 16'h0);

        // Reset during DATA abandons the frame and clears everything
        send_frame(8'h32, 0, 0, 0);
        chk("C overrun before reset", {15'b0, overrun}, 16'h1);
        partial(8'h1C, 3);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("C reset kd", kd, 16'h0000);
        chk("C reset overrun", {15'b0, overrun}, 16'h0);
        chk("C reset frame_error", {15'b0, frame_error}, 16'h0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h15, 0, 0, 0);
        chk("C after reset kd", kd_after, 16'h8015);
        chk("C after reset overrun", {15'b0, overrun}, 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
